stack_overlap_tracker: RTL and testbench
========================================

Name: stack_overlap_tracker

Overview:
- Parametrised successor to the per-drop intersection check in the block-stacker game.
- Holds the previous row's extent internally and accepts each dropped row through a valid/ready handshake.
- Computes the overlap, reports the trimmed block, and tracks row count, perfect-drop streak and game end.
- Sits between the moving-block controller (drop source) and the draw/score logic (result sink).

Parameters:
COORD_W, 9, width of horizontal pixel coordinates
MAX_ROWS, 16, rows needed to win; row_count saturates here
STREAK_W, 4, width of perfect-drop streak counter (saturating)
PERFECT_TOL, 0, max |start difference| still counted as perfect

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
new_game  in  1  synchronous clear of game state; same effect as reset
drop_valid  in  1  a dropped row is presented
drop_ready  out  1  block can accept a drop
curr_start  in  COORD_W  left edge of dropped row, inclusive
curr_end  in  COORD_W  right edge of dropped row, inclusive
result_valid  out  1  one-cycle pulse: result fields valid
hit  out  1  dropped row overlaps the previous row (or is the first row)
perfect  out  1  hit with |curr_start-prev_start| <= PERFECT_TOL and equal size
trim_start  out  COORD_W  left edge of surviving block
trim_end  out  COORD_W  right edge of surviving block
trim_size  out  COORD_W+1  trim_end-trim_start+1; 0 on miss
row_count  out  $clog2(MAX_ROWS+1)  rows successfully stacked
streak  out  STREAK_W  consecutive perfect drops
game_over  out  1  sticky: a miss occurred
win  out  1  sticky: row_count reached MAX_ROWS

Behaviour:
- Reset/new_game (reset has priority): FSM=IDLE; all outputs 0; prev extent cleared; first-row flag set. drop_ready returns to 1 in the cycle after reset deasserts.
- FSM states: IDLE, CALC, REPORT, DONE.
- IDLE:
  - drop_ready=1.
  - On drop_valid, latch curr_start/curr_end and go to CALC.
- CALC:
  - drop_ready=0.
  - Register the overlap: os=max(prev_start,curr_start), oe=min(prev_end,curr_end).
  - First row: os=curr_start, oe=curr_end; always a hit; never perfect.
  - Malformed drop (curr_end<curr_start) or os>oe: miss; trim_start/trim_end/trim_size=0.
  - All compares are unsigned; trim_size is computed at COORD_W+1 bits with no overflow.
- REPORT:
  - result_valid=1 for exactly this cycle.
  - On a hit:
    - prev extent <= trimmed extent; first-row flag cleared.
    - row_count increments, saturating at MAX_ROWS.
    - streak increments (saturating at all-ones) if perfect; otherwise streak clears.
  - On a miss: game_over set; streak cleared; prev extent and row_count unchanged.
  - Next state: DONE if miss or row_count reaches MAX_ROWS (win set); otherwise IDLE.
- DONE:
  - drop_ready=0; drop_valid ignored.
  - Result fields, row_count and streak hold their last values until reset or new_game.
- Latency: drop accepted on edge N; result_valid high in the cycle after edge N+2; next drop accepted no earlier than edge N+3.
- Result fields (hit, perfect, trim_*) hold their values after the pulse until the next REPORT.
- drop_valid while drop_ready=0 has no effect; inputs are not buffered.
- reset or new_game asserted in CALC/REPORT: the in-flight drop is discarded; no result_valid pulse.

Test Plan:
1. Reset, then first drop 100..139 -> result_valid at N+2; hit=1, perfect=0, trim 100..139, size 40, row_count=1, streak=0.
2. Next drop 110..149 -> hit=1, trim 110..139, size 30, row_count=2. Next drop 110..139 -> perfect=1, streak=1.
3. Drop 200..229 over prev 110..139 -> hit=0, trim_size=0, game_over=1, FSM DONE. A further drop_valid produces no result_valid. new_game -> all outputs 0, drop_ready=1.
4. Edge-touch drop 139..168 over 110..139 -> hit=1, trim 139..139, size 1. Malformed drop 50..40 -> miss.
5. MAX_ROWS=3: three hitting drops -> win=1 on the third REPORT, drop_ready stays 0. Streak of 15 more perfect drops (STREAK_W=4, MAX_ROWS large) -> streak saturates at 15.
6. Assert reset for one cycle during CALC -> no result_valid; row_count=0; next drop is treated as the first row.

Source files
------------

// File: rtl/stack_overlap_tracker_if.sv
// Drop/result bus between the moving-block controller, the overlap tracker and the draw/score logic.
// The master modport is the drop source and result sink; the slave modport is the tracker.
interface stack_overlap_tracker_if #(
    parameter int COORD_W  = 9,
    parameter int MAX_ROWS = 16,
    parameter int STREAK_W = 4
);
    localparam int ROW_W = $clog2(MAX_ROWS + 1);

    logic                drop_valid;
    logic                drop_ready;
    logic [COORD_W-1:0]  curr_start;
    logic [COORD_W-1:0]  curr_end;
    logic                result_valid;
    logic                hit;
    logic                perfect;
    logic [COORD_W-1:0]  trim_start;
    logic [COORD_W-1:0]  trim_end;
    logic [COORD_W:0]    trim_size;
    logic [ROW_W-1:0]    row_count;
    logic [STREAK_W-1:0] streak;
    logic                game_over;
    logic                win;

    modport master (
        output drop_valid, curr_start, curr_end,
        input  drop_ready, result_valid, hit, perfect, trim_start, trim_end,
               trim_size, row_count, streak, game_over, win
    );

    modport slave (
        input  drop_valid, curr_start, curr_end,
        output drop_ready, result_valid, hit, perfect, trim_start, trim_end,
               trim_size, row_count, streak, game_over, win
    );
endinterface

// File: rtl/stack_overlap_tracker.sv
// Block-stacker row intersection: keeps the previous row's extent, trims each dropped row
// against it and tracks stacked rows, perfect-drop streak, game over and win.
module stack_overlap_tracker #(
    parameter int COORD_W     = 9,
    parameter int MAX_ROWS    = 16,
    parameter int STREAK_W    = 4,
    parameter int PERFECT_TOL = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_game,
    stack_overlap_tracker_if.slave bus
);
    localparam int                 ROW_W    = $clog2(MAX_ROWS + 1);
    localparam logic [ROW_W-1:0]   ROWS_MAX = ROW_W'(MAX_ROWS);
    localparam logic [COORD_W-1:0] TOL      = COORD_W'(PERFECT_TOL);

    typedef enum logic [1:0] {IDLE, CALC, REPORT, DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic                r_drop_ready;
    logic                r_result_valid;
    logic [COORD_W-1:0]  r_cur_s, r_cur_e;
    logic [COORD_W-1:0]  r_prev_s, r_prev_e;
    logic                r_first;
    logic [COORD_W-1:0]  r_os, r_oe;
    logic                r_calc_hit, r_calc_perfect;
    logic                r_hit, r_perfect;
    logic [COORD_W-1:0]  r_trim_s, r_trim_e;
    logic [COORD_W:0]    r_trim_size;
    logic [ROW_W-1:0]    r_row_count;
    logic [STREAK_W-1:0] r_streak;
    logic                r_game_over, r_win;

    logic                w_clear;
    logic                w_accept;
    logic                w_ready_next;
    logic [COORD_W-1:0]  w_os, w_oe, w_start_diff;
    logic                w_hit, w_perfect;
    logic [COORD_W:0]    w_size;
    logic [ROW_W-1:0]    w_rows_inc;
    logic [STREAK_W-1:0] w_streak_inc;

    assign w_clear  = reset | new_game;
    assign w_accept = (r_state == IDLE) && r_drop_ready && bus.drop_valid;

    // The first row has nothing below it, so its overlap is simply itself.
    assign w_os = r_first ? r_cur_s : ((r_prev_s > r_cur_s) ? r_prev_s : r_cur_s);
    assign w_oe = r_first ? r_cur_e : ((r_prev_e < r_cur_e) ? r_prev_e : r_cur_e);
    assign w_hit = (r_cur_e >= r_cur_s) && (w_os <= w_oe);
    assign w_start_diff = (r_cur_s >= r_prev_s) ? (r_cur_s - r_prev_s) : (r_prev_s - r_cur_s);
    assign w_perfect = w_hit && !r_first && (w_start_diff <= TOL) &&
                       ((r_cur_e - r_cur_s) == (r_prev_e - r_prev_s));

    assign w_size       = {1'b0, r_oe} - {1'b0, r_os} + (COORD_W+1)'(1);
    assign w_rows_inc   = (r_row_count == ROWS_MAX) ? r_row_count : r_row_count + 1'b1;
    assign w_streak_inc = (r_streak == '1) ? r_streak : r_streak + 1'b1;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready_next = 1'b0;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_next = CALC;
            CALC:    w_state_next = REPORT;
            REPORT:  w_state_next = (!r_calc_hit || (w_rows_inc == ROWS_MAX)) ? DONE : IDLE;
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
        w_ready_next = (w_state_next == IDLE);
    end

    // Results are registered on the REPORT edge so the pulse and the updated counters appear together.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_drop_ready   <= 1'b0;
            r_result_valid <= 1'b0;
            r_cur_s        <= '0;
            r_cur_e        <= '0;
            r_prev_s       <= '0;
            r_prev_e       <= '0;
            r_first        <= 1'b1;
            r_os           <= '0;
            r_oe           <= '0;
            r_calc_hit     <= 1'b0;
            r_calc_perfect <= 1'b0;
            r_hit          <= 1'b0;
            r_perfect      <= 1'b0;
            r_trim_s       <= '0;
            r_trim_e       <= '0;
            r_trim_size    <= '0;
            r_row_count    <= '0;
            r_streak       <= '0;
            r_game_over    <= 1'b0;
            r_win          <= 1'b0;
        end else begin
            r_drop_ready   <= w_ready_next;
            r_result_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cur_s <= bus.curr_start;
                        r_cur_e <= bus.curr_end;
                    end
                end
                CALC: begin
                    r_os           <= w_os;
                    r_oe           <= w_oe;
                    r_calc_hit     <= w_hit;
                    r_calc_perfect <= w_perfect;
                end
                REPORT: begin
                    r_result_valid <= 1'b1;
                    r_hit          <= r_calc_hit;
                    r_perfect      <= r_calc_perfect;
                    if (r_calc_hit) begin
                        r_trim_s    <= r_os;
                        r_trim_e    <= r_oe;
                        r_trim_size <= w_size;
                        r_prev_s    <= r_os;
                        r_prev_e    <= r_oe;
                        r_first     <= 1'b0;
                        r_row_count <= w_rows_inc;
                        r_streak    <= r_calc_perfect ? w_streak_inc : '0;
                        if (w_rows_inc == ROWS_MAX) r_win <= 1'b1;
                    end else begin
                        r_trim_s    <= '0;
                        r_trim_e    <= '0;
                        r_trim_size <= '0;
                        r_streak    <= '0;
                        r_game_over <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.drop_ready   = r_drop_ready;
    assign bus.result_valid = r_result_valid;
    assign bus.hit          = r_hit;
    assign bus.perfect      = r_perfect;
    assign bus.trim_start   = r_trim_s;
    assign bus.trim_end     = r_trim_e;
    assign bus.trim_size    = r_trim_size;
    assign bus.row_count    = r_row_count;
    assign bus.streak       = r_streak;
    assign bus.game_over    = r_game_over;
    assign bus.win          = r_win;
endmodule

// File: tb/tb_stack_overlap_tracker.sv
// Bench for stack_overlap_tracker: directed game scenarios plus random games scored against
// a plain-arithmetic model of the stacking rules.
module tb_stack_overlap_tracker;
    localparam int COORD_W  = 9;
    localparam int MAX_ROWS = 20;
    localparam int STREAK_W = 4;
    localparam int TOL      = 1;
    localparam int CMAX     = (1 << COORD_W) - 1;
    localparam int SMAX     = (1 << STREAK_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic new_game = 1'b0;
    always #5 clk = ~clk;

    stack_overlap_tracker_if #(.COORD_W(COORD_W), .MAX_ROWS(MAX_ROWS), .STREAK_W(STREAK_W)) bus();

    stack_overlap_tracker #(
        .COORD_W(COORD_W), .MAX_ROWS(MAX_ROWS), .STREAK_W(STREAK_W), .PERFECT_TOL(TOL)
    ) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference game state
    bit m_first, m_over, m_win, m_hit, m_perf;
    int m_ps, m_pe, m_rows, m_streak, m_ts, m_te, m_tsz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        m_first = 1; m_over = 0; m_win = 0; m_hit = 0; m_perf = 0;
        m_ps = 0; m_pe = 0; m_rows = 0; m_streak = 0; m_ts = 0; m_te = 0; m_tsz = 0;
    endfunction

    function automatic void model_drop(input int s, input int e);
        int os, oe, d;
        os = m_first ? s : ((s > m_ps) ? s : m_ps);
        oe = m_first ? e : ((e < m_pe) ? e : m_pe);
        d  = (s > m_ps) ? s - m_ps : m_ps - s;
        m_hit  = (e >= s) && (os <= oe);
        m_perf = m_hit && !m_first && (d <= TOL) && ((e - s) == (m_pe - m_ps));
        if (m_hit) begin
            m_ts = os; m_te = oe; m_tsz = oe - os + 1;
            m_ps = os; m_pe = oe; m_first = 0;
            if (m_rows < MAX_ROWS) m_rows++;
            m_streak = m_perf ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
            if (m_rows == MAX_ROWS) m_win = 1;
        end else begin
            m_ts = 0; m_te = 0; m_tsz = 0; m_over = 1; m_streak = 0;
        end
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_hit"},   bus.hit,        m_hit);
        check({tag, "_perf"},  bus.perfect,    m_perf);
        check({tag, "_ts"},    bus.trim_start, m_ts);
        check({tag, "_te"},    bus.trim_end,   m_te);
        check({tag, "_size"},  bus.trim_size,  m_tsz);
        check({tag, "_rows"},  bus.row_count,  m_rows);
        check({tag, "_strk"},  bus.streak,     m_streak);
        check({tag, "_over"},  bus.game_over,  m_over);
        check({tag, "_win"},   bus.win,        m_win);
    endtask

    // Pulses reset or new_game for one edge and checks the cleared state and the ready return.
    task automatic do_clear(input bit use_reset);
        @(negedge clk);
        if (use_reset) reset = 1'b1; else new_game = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; new_game = 1'b0;
        model_clear();
        @(negedge clk);
        check("clr_rv",    bus.result_valid, 0);
        check("clr_ready", bus.drop_ready,   0);
        check_outputs("clr");
        @(negedge clk);
        check("clr_ready_back", bus.drop_ready, 1);
        $display("clear via %s: ready=%0d rows=%0d", use_reset ? "reset" : "new_game",
                 bus.drop_ready, bus.row_count);
    endtask

    // Presents a drop and returns #1 after the accepting edge.
    task automatic accept(input int s, input int e, output bit ok);
        int w;
        w = 0; ok = 0;
        @(negedge clk);
        while (bus.drop_ready !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (bus.drop_ready !== 1'b1) begin
            check("ready_wait", bus.drop_ready, 1);
            return;
        end
        bus.drop_valid = 1'b1;
        bus.curr_start = COORD_W'(s);
        bus.curr_end   = COORD_W'(e);
        @(posedge clk); #1;
        bus.drop_valid = 1'b0;
        bus.curr_start = COORD_W'($urandom);
        bus.curr_end   = COORD_W'($urandom);
        ok = 1;
    endtask

    task automatic drop(input int s, input int e);
        bit ok;
        accept(s, e, ok);
        if (!ok) return;
        @(negedge clk); check("rv_early1", bus.result_valid, 0);
        @(negedge clk); check("rv_early2", bus.result_valid, 0);
        @(negedge clk); check("rv_pulse",  bus.result_valid, 1);
        model_drop(s, e);
        check_outputs("res");
        check("res_ready", bus.drop_ready, !(m_over || m_win));
        $display("drop %0d..%0d: hit=%0d perf=%0d trim=%0d..%0d size=%0d rows=%0d streak=%0d over=%0d win=%0d",
                 s, e, bus.hit, bus.perfect, bus.trim_start, bus.trim_end, bus.trim_size,
                 bus.row_count, bus.streak, bus.game_over, bus.win);
        @(negedge clk);
        check("rv_single", bus.result_valid, 0);
        check("hold_size", bus.trim_size, m_tsz);
        check("hold_hit",  bus.hit,       m_hit);
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_rv"}, bus.result_valid, 0);
        end
    endtask

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > CMAX) ? CMAX : v);
    endfunction

    task automatic random_drop();
        int mode, s, e, w;
        mode = int'($urandom_range(0, 9));
        if (m_first || mode >= 7) begin
            s = int'($urandom_range(0, CMAX));
            e = clampc(s + int'($urandom_range(0, 100)));
        end else if (mode == 0) begin
            s = int'($urandom_range(1, CMAX));
            e = s - int'($urandom_range(1, s));
        end else if (mode <= 3) begin
            w = m_pe - m_ps;
            s = clampc(m_ps + int'($urandom_range(0, 4)) - 2);
            e = s + w;
            if (e > CMAX) begin e = CMAX; s = CMAX - w; end
        end else begin
            s = clampc(m_ps + int'($urandom_range(0, 40)) - 20);
            e = clampc(s + int'($urandom_range(0, 60)));
        end
        drop(s, e);
    endtask

    initial begin
        bit ok;
        bus.drop_valid = 1'b0;
        bus.curr_start = '0;
        bus.curr_end   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        do_clear(1'b1);

        // Basic stacking, trimming, perfect drop and a miss
        drop(100, 139);
        drop(110, 149);
        drop(110, 139);
        drop(200, 229);

        // Drops while finished are ignored
        @(negedge clk);
        bus.drop_valid = 1'b1; bus.curr_start = 9'd50; bus.curr_end = 9'd60;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("done_rv",    bus.result_valid, 0);
            check("done_ready", bus.drop_ready,   0);
        end
        bus.drop_valid = 1'b0;
        check("done_rows", bus.row_count, m_rows);
        check("done_over", bus.game_over, 1);

        // Edge-touching overlap, tolerance-perfect drop, malformed drop
        do_clear(1'b0);
        drop(110, 139);
        drop(139, 168);
        drop(139, 139);
        drop(140, 140);
        do_clear(1'b0);
        drop(200, 240);
        drop(201, 241);
        drop(50, 40);

        // Reset during CALC discards the drop; next drop is a first row
        do_clear(1'b0);
        drop(100, 139);
        accept(400, 450, ok);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        expect_silence("rst_calc", 4);
        check("rst_calc_rows", bus.row_count, 0);
        drop(300, 310);

        // new_game during REPORT discards the drop
        accept(305, 320, ok);
        @(posedge clk); #1;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
        model_clear();
        expect_silence("ng_report", 4);
        check("ng_report_rows", bus.row_count, 0);
        drop(0, CMAX);
        drop(CMAX, CMAX);

        // Full perfect run: streak saturates, win at MAX_ROWS
        do_clear(1'b0);
        for (int i = 0; i < MAX_ROWS; i++) drop(200, 240);
        @(negedge clk);
        check("win_ready", bus.drop_ready, 0);

        // Random games
        for (int g = 0; g < 25; g++) begin
            do_clear(1'b0);
            for (int k = 0; k < 30 && !(m_over || m_win); k++) random_drop();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
